// File: rtl/mux4x_nbit.sv
// Registered 4-to-1 multiplexer for BUS_WIDTH-bit words with a valid flag.
// Optional input register stage is enabled by defining MUX4X_NBIT_IN_REG_EN,
// which moves the latency from 1 clk to 2 clk.
module mux4x_nbit #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic [BUS_WIDTH-1:0] d,
  input  logic [1:0]           sel,
  input  logic                 in_valid,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 out_valid
);

  // Signals that feed the output stage.
  logic [BUS_WIDTH-1:0] s_a, s_b, s_c, s_d;
  logic [1:0]           s_sel;
  logic                 s_vld;

`ifdef MUX4X_NBIT_IN_REG_EN
  logic [BUS_WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic [1:0]           sel_q;
  logic                 vld_q;

  // Input stage: capture every cycle; valid qualifies the word downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      sel_q <= '0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      c_q   <= c;
      d_q   <= d;
      sel_q <= sel;
      vld_q <= in_valid;
    end
  end

  assign s_a   = a_q;
  assign s_b   = b_q;
  assign s_c   = c_q;
  assign s_d   = d_q;
  assign s_sel = sel_q;
  assign s_vld = vld_q;
`else
  assign s_a   = a;
  assign s_b   = b;
  assign s_c   = c;
  assign s_d   = d;
  assign s_sel = sel;
  assign s_vld = in_valid;
`endif

  logic [BUS_WIDTH-1:0] mux_d;
  logic [BUS_WIDTH-1:0] y_q, y_d;
  logic                 out_valid_q, out_valid_d;

  // Select decode; only the chosen source reaches mux_d, so X elsewhere is masked.
  always_comb begin
    mux_d = '0;
    case (s_sel)
      2'd0:    mux_d = s_a;
      2'd1:    mux_d = s_b;
      2'd2:    mux_d = s_c;
      default: mux_d = s_d;
    endcase
  end

  // Next state: capture on valid, otherwise hold data and drop the flag.
  always_comb begin
    y_d         = y_q;
    out_valid_d = s_vld;
    if (s_vld) begin
      y_d = mux_d;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux4x_nbit.sv
// Directed bench for mux4x_nbit at widths 8, 1 and 32, plus a random run on
// the 8-bit instance against a small latency-aware reference model.
module tb_mux4x_nbit;

`ifdef MUX4X_NBIT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        in_valid;

  logic [7:0]  a8, b8, c8, d8, y8;
  logic        ov8;
  logic        a1, b1, c1, d1, y1;
  logic        ov1;
  logic [31:0] a32, b32, c32, d32, y32;
  logic        ov32;

  int total = 0;
  int bad   = 0;

  // Reference model state for the random run.
  logic        pv [LAT];
  logic [7:0]  pd [LAT];
  logic [7:0]  y_m;
  logic        ov_m;

  always #5 clk = ~clk;

  mux4x_nbit #(.BUS_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8), .sel(sel),
    .in_valid(in_valid), .y(y8), .out_valid(ov8)
  );

  mux4x_nbit #(.BUS_WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel),
    .in_valid(in_valid), .y(y1), .out_valid(ov1)
  );

  mux4x_nbit #(.BUS_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .c(c32), .d(d32), .sel(sel),
    .in_valid(in_valid), .y(y32), .out_valid(ov32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample point: 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] xa,
                                      input logic [7:0] xb, input logic [7:0] xc,
                                      input logic [7:0] xd);
    case (s)
      2'd0:    return xa;
      2'd1:    return xb;
      2'd2:    return xc;
      default: return xd;
    endcase
  endfunction

  initial begin
    logic [7:0] sweep [4];
    logic [7:0] nxt;
    sweep[0] = 8'h11; sweep[1] = 8'h22; sweep[2] = 8'h33; sweep[3] = 8'h44;

    rst = 1'b0; sel = 2'd0; in_valid = 1'b1;
    a8 = 8'hFF; b8 = '0; c8 = '0; d8 = '0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0;
    a32 = '0; b32 = '0; c32 = '0; d32 = '0;

    // Reset: asynchronous clear before any clock edge, held across edges.
    #1 rst = 1'b1;
    #1;
    check("rst_async_y", 64'(y8), 64'h0);
    check("rst_async_ov", 64'(ov8), 64'h0);
    tick();
    tick();
    check("rst_hold_y", 64'(y8), 64'h0);
    check("rst_hold_ov", 64'(ov8), 64'h0);
    rst = 1'b0;
    #2;
    check("rst_rel_y", 64'(y8), 64'h0);
`ifdef MUX4X_NBIT_IN_REG_EN
    tick();
    check("rst_first_ov_pipe", 64'(ov8), 64'h0);
    tick();
`else
    tick();
`endif
    check("rst_first_y", 64'(y8), 64'hFF);
    check("rst_first_ov", 64'(ov8), 64'h1);

    // Select sweep, back-to-back valid.
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      if (i < 4) sel = 2'(i);
      tick();
      if (i >= LAT - 1) begin
        check($sformatf("sweep_y%0d", i - LAT + 1), 64'(y8), 64'(sweep[i - LAT + 1]));
        check($sformatf("sweep_ov%0d", i - LAT + 1), 64'(ov8), 64'h1);
      end
    end

    // Hold: one capture of c = A5, then inputs churn while invalid.
    sel = 2'd2; c8 = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) tick();
    check("hold_cap_y", 64'(y8), 64'hA5);
    check("hold_cap_ov", 64'(ov8), 64'h1);
    for (int i = 0; i < 5; i++) begin
      sel = 2'(i); a8 = 8'(i * 37); b8 = ~b8; c8 = 8'(i + 1); d8 = ~d8;
      tick();
      check($sformatf("hold_y%0d", i), 64'(y8), 64'hA5);
      check($sformatf("hold_ov%0d", i), 64'(ov8), 64'h0);
    end

    // X on unselected sources must stay out of y.
    a8 = 'x; c8 = 'x; d8 = 'x; b8 = 8'h5A; sel = 2'd1; in_valid = 1'b1;
    for (int i = 0; i < LAT; i++) tick();
    check("xmask_y", 64'(y8), 64'h5A);

    // Boundary data at all three widths via source d.
    a8 = '0; b8 = '0; c8 = '0; sel = 2'd3;
    d8 = 8'hFF; d1 = 1'b1; d32 = 32'hFFFF_FFFF;
    for (int i = 0; i < LAT; i++) tick();
    check("w8_ones", 64'(y8), 64'hFF);
    check("w1_ones", 64'(y1), 64'h1);
    check("w32_ones", 64'(y32), 64'hFFFF_FFFF);
    check("w32_ov", 64'(ov32), 64'h1);
    d8 = 8'h00; d1 = 1'b0; d32 = '0;
    for (int i = 0; i < LAT; i++) tick();
    check("w8_zero", 64'(y8), 64'h00);
    check("w1_zero", 64'(y1), 64'h0);
    check("w32_zero", 64'(y32), 64'h0);

    // Random traffic against the model, starting from a fresh reset.
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    y_m = '0;
    for (int n = 0; n < 1000; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
      sel = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom);
      nxt = pick(sel, a8, b8, c8, d8);
      tick();
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i - 1];
        pd[i] = pd[i - 1];
      end
      pv[0] = in_valid;
      pd[0] = nxt;
      ov_m = pv[LAT - 1];
      if (ov_m) y_m = pd[LAT - 1];
      check($sformatf("rand_y%0d", n), 64'(y8), 64'(y_m));
      check($sformatf("rand_ov%0d", n), 64'(ov8), 64'(ov_m));
    end

    // Mid-stream reset: half-period pulse between edges discards in-flight data.
    a8 = '0; c8 = '0; d8 = '0; sel = 2'd1; b8 = 8'h3C; in_valid = 1'b1;
    for (int i = 0; i < LAT; i++) tick();
    check("mid_pre_y", 64'(y8), 64'h3C);
    #2 rst = 1'b1;
    #1;
    check("mid_async_y", 64'(y8), 64'h0);
    check("mid_async_ov", 64'(ov8), 64'h0);
    #4 rst = 1'b0;
    b8 = 8'h7E;
`ifdef MUX4X_NBIT_IN_REG_EN
    tick();
    check("mid_nostale_y", 64'(y8), 64'h0);
    check("mid_nostale_ov", 64'(ov8), 64'h0);
`endif
    tick();
    check("mid_resume_y", 64'(y8), 64'h7E);
    check("mid_resume_ov", 64'(ov8), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4x_nbit.md
Name: mux4x_nbit

Overview:
Registered 4-to-1 multiplexer for BUS_WIDTH-bit data words. It selects one of four input buses (a, b, c, d) with a 2-bit select and presents the selection on a registered output with a valid flag. It is a generic datapath steering element used wherever one of four equal-width sources feeds a single sink.

Parameters:
BUS_WIDTH, 8, width in bits of each data input and of the output (legal range 1..64).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
a  input  BUS_WIDTH  data source 0.
b  input  BUS_WIDTH  data source 1.
c  input  BUS_WIDTH  data source 2.
d  input  BUS_WIDTH  data source 3.
sel  input  2  source select: 0 selects a, 1 selects b, 2 selects c, 3 selects d.
in_valid  input  1  qualifies a/b/c/d/sel for the current cycle.
y  output  BUS_WIDTH  registered selected data.
out_valid  output  1  high for exactly the cycle(s) where y holds a newly captured value.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset: while rst is high, y = 0 and out_valid = 0 immediately, independent of clk. First capture occurs on the first rising clk edge after rst deasserts.
- Select decode is purely combinational and full: sel 0/1/2/3 selects a/b/c/d. No default/X case is reachable.
- Capture: on a rising clk edge with in_valid = 1, y <= selected input and out_valid <= 1.
- Hold: on a rising clk edge with in_valid = 0, y keeps its previous value and out_valid <= 0.
- Latency: 1 clk from in_valid/data/sel sample to y/out_valid, with the default build.
- Throughput: one word per cycle. Back-to-back in_valid is legal, and y updates every cycle.
- sel or data changes while in_valid = 0 have no effect on y.
- Width: y is exactly BUS_WIDTH bits, with no extension or truncation. The data path passes all values 0..2^BUS_WIDTH-1 unchanged.
- Reset mid-stream: asserting rst with in_valid high discards the in-flight word. y = 0 and out_valid = 0 until the next valid capture after release.
- X on an unselected input must not propagate to y.

Optional Feature:
MUX4X_NBIT_IN_REG_EN:
- Defined: adds an input register stage that captures a, b, c, d, sel and in_valid on each rising clk edge. This stage is reset asynchronously by rst (data 0, valid 0). Latency becomes 2 clk; throughput is still one word per cycle. The hold and valid rules apply at the output stage using the registered in_valid.
- Not defined: single register stage, 1-clk latency, as described above.

Test Plan:
1. Reset: rst = 1 with a = 8'hFF and in_valid = 1 -> y = 0 and out_valid = 0 immediately and throughout reset. After release, the first capture appears 1 clk after the first valid edge.
2. Select sweep: a = 8'h11, b = 8'h22, c = 8'h33, d = 8'h44, in_valid = 1, sel stepped 0,1,2,3 on consecutive cycles -> y = 11, 22, 33, 44 on the following cycles, with out_valid held high.
3. Hold: capture sel = 2, c = 8'hA5, then in_valid = 0 while sel and all inputs toggle for 5 cycles -> y stays A5 and out_valid = 0 for those cycles.
4. Boundary data: BUS_WIDTH = 8, sel = 3, d = 8'hFF, then d = 8'h00 -> y = FF, then 00. Repeat with BUS_WIDTH = 1 and BUS_WIDTH = 32 using an all-ones pattern -> exact match.
5. Random: 1000 cycles of random sel in 0..3, random a–d and random in_valid -> y matches the reference model delayed 1 clk (2 clk with MUX4X_NBIT_IN_REG_EN), and out_valid matches the delayed in_valid.
6. Mid-stream reset: continuous valid traffic, rst pulsed for half a clk period between edges -> y = 0 and out_valid = 0 asynchronously. Traffic resumes correctly on the next valid edge with no stale word.
